// File: rtl/det101_event_collector.sv
// Collects per-lane "101" detector matches: saturating lane counters plus a
// timestamped show-ahead event FIFO drained over a valid/ready handshake.
module det101_event_collector #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 y,
  input  logic                       clr_cnt,
  input  logic                       ev_ready,
  output logic                       ev_valid,
  output logic [2:0]                 ev_mask,
  output logic [TS_W-1:0]            ev_ts,
  output logic                       ev_ovf,
  output logic [CNT_W-1:0]           cnt_l0,
  output logic [CNT_W-1:0]           cnt_l1,
  output logic [CNT_W-1:0]           cnt_l2,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + TS_W;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_cnt [3];
  logic             r_ovf;

  logic             w_empty;
  logic             w_full;
  logic             w_hit;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [EW-1:0]    w_head;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_hit   = en && (y != 3'b000);
  assign w_pop   = !w_empty && ev_ready;
  assign w_push  = w_hit && (!w_full || w_pop);
  assign w_drop  = w_hit && w_full && !w_pop;
  assign w_head  = r_mem[r_rdPtr[AW-1:0]];

  assign ev_valid = !w_empty;
  assign ev_mask  = w_empty ? 3'b000 : w_head[EW-1:TS_W];
  assign ev_ts    = w_empty ? '0 : w_head[TS_W-1:0];
  assign ev_ovf   = r_ovf;
  assign cnt_l0   = r_cnt[0];
  assign cnt_l1   = r_cnt[1];
  assign cnt_l2   = r_cnt[2];
  assign level    = r_wrPtr - r_rdPtr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_ts    <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_push) begin
        r_mem[r_wrPtr[AW-1:0]] <= {y, r_ts};
        r_wrPtr                <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // A clear wins over a same-cycle increment or overflow set.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_ovf <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (en && y[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_det101_event_collector.sv
// Directed self-checking bench for det101_event_collector, using a small
// configuration (TS_W=4, CNT_W=4, DEPTH=8) so that wrap and saturation are short.
module tb_det101_event_collector;

  localparam int TS_W  = 4;
  localparam int CNT_W = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       y;
  logic             clr_cnt;
  logic             ev_ready;
  logic             ev_valid;
  logic [2:0]       ev_mask;
  logic [TS_W-1:0]  ev_ts;
  logic             ev_ovf;
  logic [CNT_W-1:0] cnt_l0;
  logic [CNT_W-1:0] cnt_l1;
  logic [CNT_W-1:0] cnt_l2;
  logic [3:0]       level;

  int checks = 0;
  int errors = 0;

  det101_event_collector #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .y(y), .clr_cnt(clr_cnt),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_mask(ev_mask),
    .ev_ts(ev_ts), .ev_ovf(ev_ovf), .cnt_l0(cnt_l0), .cnt_l1(cnt_l1),
    .cnt_l2(cnt_l2), .level(level)
  );

  always #5 clk = ~clk;

  // Drive inputs, then advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic iRst, input logic iEn,
                               input logic [2:0] iY, input logic iReady,
                               input logic iClr);
    rst      = iRst;
    en       = iEn;
    y        = iY;
    ev_ready = iReady;
    clr_cnt  = iClr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed,
                             input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag, input int c0, input int c1,
                             input int c2);
    checkOutput({tag, "_cnt0"}, int'(cnt_l0), c0);
    checkOutput({tag, "_cnt1"}, int'(cnt_l1), c1);
    checkOutput({tag, "_cnt2"}, int'(cnt_l2), c2);
  endtask

  task automatic checkHead(input string tag, input int valid, input int mask,
                           input int ts);
    checkOutput({tag, "_valid"}, int'(ev_valid), valid);
    checkOutput({tag, "_mask"}, int'(ev_mask), mask);
    checkOutput({tag, "_ts"}, int'(ev_ts), ts);
  endtask

  initial begin
    int expTs [8];
    int expMask [8];

    // Reset state
    applyStimulus(1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    checkHead("reset", 0, 0, 0);
    checkOutput("reset_level", int'(level), 0);
    checkOutput("reset_ovf", int'(ev_ovf), 0);
    checkCounts("reset", 0, 0, 0);

    // Single events: y=001 sampled at ts 5, y=101 at ts 9
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("idle", 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
    checkHead("ev1", 1, 3'b001, 5);
    checkOutput("ev1_level", int'(level), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("ev1_popped", 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 3'b101, 1'b1, 1'b0);
    checkHead("ev2", 1, 3'b101, 9);
    checkCounts("single", 2, 0, 1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("ev2_popped", 0, 0, 0);
    checkOutput("ev2_level", int'(level), 0);

    // Overflow: 10 pushes with no pops, samples ts 11..15,0..4
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    checkOutput("ovf_level", int'(level), 8);
    checkOutput("ovf_flag", int'(ev_ovf), 1);
    checkCounts("ovf", 2, 10, 1);
    checkHead("ovf_head", 1, 3'b010, 11);

    // Push and pop together at full: sample at ts 5 goes to the tail
    applyStimulus(1'b0, 1'b1, 3'b100, 1'b1, 1'b0);
    checkOutput("pp_level", int'(level), 8);
    checkOutput("pp_ovf", int'(ev_ovf), 1);
    checkCounts("pp", 2, 10, 2);

    expTs   = '{12, 13, 14, 15, 0, 1, 2, 5};
    expMask = '{2, 2, 2, 2, 2, 2, 2, 4};
    for (int i = 0; i < 8; i++) begin
      checkHead($sformatf("drain%0d", i), 1, expMask[i], expTs[i]);
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    end
    checkHead("drained", 0, 0, 0);
    checkOutput("drained_level", int'(level), 0);

    // Saturation: ts now 14, 20 edges of y=111 end at ts 2
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 3'b111, 1'b1, 1'b0);
    checkCounts("sat", 15, 15, 15);
    checkOutput("sat_ovf", int'(ev_ovf), 1);
    checkOutput("sat_level", int'(level), 1);
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b1, 1'b1);
    checkCounts("clr", 0, 0, 0);
    checkOutput("clr_ovf", int'(ev_ovf), 0);
    checkHead("clr_head", 1, 3'b111, 2);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("clr_drain", 0, 0, 0);

    // Gating: en low ignores y (ts 4..8)
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 3'b111, 1'b1, 1'b0);
    checkHead("gate", 0, 0, 0);
    checkOutput("gate_level", int'(level), 0);
    checkCounts("gate", 0, 0, 0);

    // Timestamp wrap: samples at ts 9..15 then 0
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
      checkHead($sformatf("wrap%0d", i), 1, 3'b001, (9 + i) % 16);
    end
    checkCounts("wrap", 8, 0, 0);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("wrap_drain", 0, 0, 0);

    // Reset mid-operation with 3 queued events
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    checkOutput("mid_level", int'(level), 3);
    checkHead("mid_head", 1, 3'b010, 2);
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
    checkHead("mid_rst", 0, 0, 0);
    checkOutput("mid_rst_level", int'(level), 0);
    checkCounts("mid_rst", 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
    checkHead("post_rst", 1, 3'b001, 0);
    checkOutput("post_rst_level", int'(level), 1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    checkHead("post_rst_drain", 0, 0, 0);
    checkCounts("post_rst", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
